// File: rtl/unidadcontrol.sv
// Microprogrammed control unit: loadable microprogram sequenced by a uPC,
// driving the 16-bit control word and branching on the processing unit's flags.
module unidadcontrol #(
  parameter int AW    = 4,
  parameter int START = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       stateBits,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [18+AW:0]   prog_data,
  output logic [15:0]      ctr_word,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    upc,
  output logic [7:0]       steps
);

  localparam int DEPTH = 2**AW;
  localparam int WW    = 19 + AW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   upc_reg, upc_next;
  logic [7:0]      steps_reg, steps_next;

  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   uword;
  logic [2:0]      cond;
  logic [AW-1:0]   target;
  logic            taken;
  logic            flag_v, flag_s, flag_z, flag_c;

  // Microprogram store has no reset so a loaded program survives an abort.
  always_ff @(posedge clk) begin
    if (prog_we && state_reg == IDLE)
      mem[prog_addr] <= prog_data;
  end

  assign uword  = mem[upc_reg];
  assign cond   = uword[WW-1 -: 3];
  assign target = uword[16 +: AW];

  assign {flag_v, flag_s, flag_z, flag_c} = stateBits;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b001:  taken = 1'b1;
      3'b010:  taken = flag_z;
      3'b011:  taken = ~flag_z;
      3'b100:  taken = flag_c;
      3'b101:  taken = flag_s;
      3'b110:  taken = flag_v;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      upc_reg   <= '0;
      steps_reg <= '0;
    end else begin
      state_reg <= state_next;
      upc_reg   <= upc_next;
      steps_reg <= steps_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    upc_next   = upc_reg;
    steps_next = steps_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          upc_next   = AW'(START);
          steps_next = '0;
        end
      end
      RUN: begin
        if (steps_reg != 8'hFF)
          steps_next = steps_reg + 8'd1;
        // Halt keeps uPC on the halt word; other conds fall through or branch.
        if (cond == 3'b111)
          state_next = DONE;
        else if (taken)
          upc_next = target;
        else
          upc_next = upc_reg + AW'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ctr_word = (state_reg == RUN) ? uword[15:0] : 16'h0000;
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign upc      = upc_reg;
  assign steps    = steps_reg;

endmodule

// File: tb/tb_unidadcontrol.sv
// Self-checking bench for unidadcontrol: directed vector tables, hand sequences
// and randomized microprograms checked against an interpreter-style model.
module tb_unidadcontrol;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  stateBits;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [22:0] prog_data;

  logic [15:0] ctr_word, ctr_word15;
  logic        busy, busy15, done, done15;
  logic [3:0]  upc, upc15;
  logic [7:0]  steps, steps15;

  int tests = 0;
  int fails = 0;

  logic [22:0] m_mem [16];

  typedef struct {
    logic [3:0]  flags;
    logic        st;
    logic [3:0]  upc;
    logic [15:0] ctr;
    logic        busy;
    logic        done;
    logic [7:0]  steps;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  unidadcontrol #(.AW(4), .START(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stateBits(stateBits),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ctr_word(ctr_word), .busy(busy), .done(done), .upc(upc), .steps(steps)
  );

  unidadcontrol #(.AW(4), .START(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .start(start), .stateBits(stateBits),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ctr_word(ctr_word15), .busy(busy15), .done(done15), .upc(upc15), .steps(steps15)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [22:0] enc(input logic [2:0] c, input logic [3:0] nx, input logic [15:0] ctrl);
    return {c, nx, ctrl};
  endfunction

  function automatic logic [22:0] rand_word();
    logic [2:0] c;
    c = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    return enc(c, 4'($urandom), 16'($urandom));
  endfunction

  function automatic vec_t mk(input logic [3:0] f, input logic st, input logic [3:0] u,
                              input logic [15:0] c, input logic b, input logic d, input logic [7:0] s);
    vec_t v;
    v.flags = f; v.st = st; v.upc = u; v.ctr = c; v.busy = b; v.done = d; v.steps = s;
    return v;
  endfunction

  task automatic write_word(input logic [3:0] a, input logic [22:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    m_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic apply_table(input string tag);
    foreach (tbl[i]) begin
      check({tag, "_upc"},   32'(upc),      32'(tbl[i].upc));
      check({tag, "_ctr"},   32'(ctr_word), 32'(tbl[i].ctr));
      check({tag, "_busy"},  32'(busy),     32'(tbl[i].busy));
      check({tag, "_done"},  32'(done),     32'(tbl[i].done));
      check({tag, "_steps"}, 32'(steps),    32'(tbl[i].steps));
      start = tbl[i].st; stateBits = tbl[i].flags;
      @(negedge clk);
    end
    $display("[TB] table %s: %0d vectors applied", tag, tbl.size());
    tbl.delete();
    start = 1'b0;
  endtask

  // Reset between clock edges: everything must clear without waiting for a clock.
  task automatic abort_run();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_ctr",   32'(ctr_word), 32'd0);
    check("rst_upc",   32'(upc),      32'd0);
    check("rst_steps", 32'(steps),    32'd0);
    @(negedge clk);
    check("rst_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
  endtask

  // Executes a run from uPC 0 by interpreting the model memory one microinstruction at a time.
  task automatic run_model(input bit wr_with_start, input bit inject, input int rst_at, input int budget);
    logic [22:0] w;
    logic [3:0]  m_upc;
    logic [3:0]  f;
    int          m_steps;
    bit          halted;
    bit          tk;
    start = 1'b1; m_upc = 4'd0; m_steps = 0; halted = 1'b0;
    if (wr_with_start) begin
      prog_we = 1'b1; prog_addr = 4'($urandom); prog_data = rand_word();
      m_mem[prog_addr] = prog_data;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    for (int cyc = 0; cyc < budget && !halted; cyc++) begin
      check("run_busy",  32'(busy),     32'd1);
      check("run_upc",   32'(upc),      32'(m_upc));
      check("run_ctr",   32'(ctr_word), 32'(m_mem[m_upc][15:0]));
      check("run_steps", 32'(steps),    32'(m_steps));
      if (cyc == rst_at) begin
        abort_run();
        $display("[TB] run aborted by reset at cycle %0d", cyc);
        return;
      end
      f = 4'($urandom);
      stateBits = f;
      if (inject && cyc == 2) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = rand_word();
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      w = m_mem[m_upc];
      case (w[22:20])
        3'd1:    tk = 1'b1;
        3'd2:    tk = f[1];
        3'd3:    tk = !f[1];
        3'd4:    tk = f[0];
        3'd5:    tk = f[2];
        3'd6:    tk = f[3];
        default: tk = 1'b0;
      endcase
      m_steps = (m_steps >= 255) ? 255 : m_steps + 1;
      if (w[22:20] == 3'd7) halted = 1'b1;
      else m_upc = tk ? w[19:16] : m_upc + 4'd1;
      @(negedge clk);
    end
    start = 1'b0; prog_we = 1'b0;
    if (halted) begin
      check("halt_done",  32'(done),     32'd1);
      check("halt_busy",  32'(busy),     32'd0);
      check("halt_ctr",   32'(ctr_word), 32'd0);
      check("halt_upc",   32'(upc),      32'(m_upc));
      check("halt_steps", 32'(steps),    32'(m_steps));
      @(negedge clk);
      check("idle_done",  32'(done),  32'd0);
      check("idle_steps", 32'(steps), 32'(m_steps));
      $display("[TB] run halted at upc %0d after %0d steps", m_upc, m_steps);
    end else begin
      $display("[TB] run still looping after %0d cycles, steps %0d", budget, m_steps);
      abort_run();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stateBits = 4'd0;
    prog_we = 1'b0; prog_addr = 4'd0; prog_data = '0;
    foreach (m_mem[i]) m_mem[i] = '0;

    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ctr",  32'(ctr_word), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(4'd0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 8'd0));
    end
    apply_table("idle");

    // Straight-line program ending in a halt.
    write_word(4'd0, enc(3'd0, 4'd0, 16'h2400));
    write_word(4'd1, enc(3'd0, 4'd0, 16'h2480));
    write_word(4'd2, enc(3'd7, 4'd0, 16'h0000));
    tbl.push_back(mk(4'd0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(4'd0, 1'b0, 4'd0, 16'h2400, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(4'd0, 1'b0, 4'd1, 16'h2480, 1'b1, 1'b0, 8'd1));
    tbl.push_back(mk(4'd0, 1'b0, 4'd2, 16'h0000, 1'b1, 1'b0, 8'd2));
    tbl.push_back(mk(4'd0, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b1, 8'd3));
    tbl.push_back(mk(4'd0, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b0, 8'd3));
    apply_table("straight");

    // Branch on Z at word 1: taken goes to 5, not taken falls to 2.
    write_word(4'd0, enc(3'd0, 4'd0, 16'h1111));
    write_word(4'd1, enc(3'd2, 4'd5, 16'h2222));
    write_word(4'd2, enc(3'd7, 4'd0, 16'h3333));
    write_word(4'd5, enc(3'd7, 4'd0, 16'h5555));
    tbl.push_back(mk(4'b0010, 1'b1, 4'd2, 16'h0000, 1'b0, 1'b0, 8'd3));
    tbl.push_back(mk(4'b0010, 1'b0, 4'd0, 16'h1111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(4'b0010, 1'b0, 4'd1, 16'h2222, 1'b1, 1'b0, 8'd1));
    tbl.push_back(mk(4'b0010, 1'b0, 4'd5, 16'h5555, 1'b1, 1'b0, 8'd2));
    tbl.push_back(mk(4'b0000, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b1, 8'd3));
    tbl.push_back(mk(4'b0000, 1'b1, 4'd5, 16'h0000, 1'b0, 1'b0, 8'd3));
    tbl.push_back(mk(4'b0000, 1'b0, 4'd0, 16'h1111, 1'b1, 1'b0, 8'd0));
    tbl.push_back(mk(4'b0000, 1'b0, 4'd1, 16'h2222, 1'b1, 1'b0, 8'd1));
    tbl.push_back(mk(4'b0000, 1'b0, 4'd2, 16'h3333, 1'b1, 1'b0, 8'd2));
    tbl.push_back(mk(4'b0000, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b1, 8'd3));
    apply_table("branch");

    // Wrap: instance started at 15 increments into word 0, which halts.
    abort_run();
    write_word(4'd15, enc(3'd0, 4'd0, 16'h00AA));
    write_word(4'd0,  enc(3'd7, 4'd0, 16'h0BB0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wrap_upc0",  32'(upc15), 32'd15);
    check("wrap_ctr0",  32'(ctr_word15), 32'h00AA);
    check("wrap_busy0", 32'(busy15), 32'd1);
    @(negedge clk);
    check("wrap_upc1",  32'(upc15), 32'd0);
    check("wrap_ctr1",  32'(ctr_word15), 32'h0BB0);
    @(negedge clk);
    check("wrap_done",  32'(done15), 32'd1);
    check("wrap_busy",  32'(busy15), 32'd0);
    check("wrap_upc2",  32'(upc15), 32'd0);
    check("wrap_steps", 32'(steps15), 32'd2);
    @(negedge clk);
    check("wrap_done_end", 32'(done15), 32'd0);
    $display("[TB] wrap sequence complete");

    // start/prog_we mid-run are ignored; word 3 read back on the re-run.
    for (int a = 0; a < 4; a++) write_word(4'(a), enc(3'd0, 4'd0, 16'(16'h0101 * (a + 1))));
    write_word(4'd4, enc(3'd7, 4'd0, 16'h0505));
    run_model(1'b0, 1'b1, -1, 50);
    run_model(1'b0, 1'b0, -1, 50);

    // Asynchronous reset in cycle 2, then the same program re-runs cleanly.
    run_model(1'b0, 1'b0, 2, 50);
    run_model(1'b0, 1'b0, -1, 50);

    // Random microprograms; long loops exercise steps saturation before an abort.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) write_word(4'(a), rand_word());
      run_model(r[0], (r % 3) == 0, -1, 300);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unidadcontrol.md
# unidadcontrol

Microprogrammed control unit that sits directly upstream of `unidadprocesadora`. It stores a loadable microprogram and sequences it with a micro-program counter (μPC). Each step it drives the 16-bit control word (fields A/B/D/F/H) into the processing unit. It branches on the registered `stateBits` {V,S,Z,C} that the processing unit returns.

## Interface
Parameters:
- `AW`, 4: μPC / microprogram address width (2**AW words).
- `START`, 0: μPC value loaded on `start`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin execution at `START`; sampled only in IDLE.
- `stateBits`  in  4  {V,S,Z,C} from the processing unit.
- `prog_we`  in  1  microprogram write enable; honoured only in IDLE.
- `prog_addr`  in  AW  microprogram write address.
- `prog_data`  in  19+AW  microinstruction {cond[2:0], next[AW-1:0], ctrl[15:0]}.
- `ctr_word`  out  16  control word to the processing unit.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after a halt retires.
- `upc`  out  AW  current μPC.
- `steps`  out  8  microinstructions executed in the current run; saturates at 255.

## Operation
- Microprogram memory: 2**AW words of width 19+AW.
  - Synchronous write on `clk` when `prog_we` is high and the state is IDLE.
  - Combinational read at `upc`.
  - Memory is not cleared by reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE with `start`=1: go to RUN, `upc`<=START, `steps`<=0.
  - RUN: execute the word at `upc`, then apply the next-μPC rule below. `steps` increments each RUN cycle, saturating at 255.
  - RUN with cond=111: go to DONE; `upc` holds.
  - DONE: go to IDLE unconditionally.
- `ctr_word` = mem[upc].ctrl in RUN, otherwise 16'h0000. 16'h0000 is the NOP word: D=0, so there is no register-file write.
- Next-μPC by cond, with taken = `next` and not-taken = `upc`+1 (mod 2**AW):
  - 000: increment.
  - 001: jump.
  - 010: branch if Z.
  - 011: branch if !Z.
  - 100: branch if C.
  - 101: branch if S.
  - 110: branch if V.
  - 111: halt.
- Flags tested are `stateBits` as presented in the same cycle. These are the flags registered from the previous microinstruction's ALU operation. Flag decisions therefore lag by exactly one microinstruction.
- A halt word's own ctrl is still driven during its cycle. It therefore executes, and its register write lands.
- `start` is ignored in RUN and DONE. `prog_we` is ignored in RUN and DONE, and memory is unchanged.
- `upc` wraps: increment from 2**AW-1 gives 0.

## Timing
- Reset (async, `rst_n`=0), effective immediately without waiting for a clock edge:
  - state IDLE.
  - `upc`=0, `steps`=0, `busy`=0, `done`=0.
  - `ctr_word`=16'h0000.
- Reset asserted mid-RUN aborts the run immediately. `done` is not pulsed. Memory contents are retained.
- `start` sampled high at edge k: `busy`=1 and `ctr_word`=mem[START].ctrl after edge k, i.e. a 1-cycle latency.
- One microinstruction per clock while in RUN; there are no stalls.
- Halt word in cycle h:
  - `busy` falls after edge h.
  - `done`=1 for cycle h+1 (DONE state).
  - IDLE from edge h+1.
  - A new `start` is accepted at edge h+2 at the earliest.
- Programming write at edge k is readable combinationally in cycle k+1.
- A `prog_we` and `start` in the same IDLE cycle both take effect. The run starts with the written word in place.
- `steps` after halt holds the count, halt word included, until the next `start`.

## Test plan
- Reset/idle: hold `rst_n`=0, then release, with `start`=0 for 5 cycles. Required: `ctr_word`=0000, `busy`=0, `done`=0, `upc`=0 throughout.
- Straight-line + halt: load words 0,1,2 with ctrl 2400/2480/0000, cond 000/000/111. Pulse `start`. Required:
  - `ctr_word` sequence 2400, 2480, 0000.
  - `done` pulses 1 cycle later.
  - `steps`=3.
- Conditional branch: word 1 has cond=010 and next=5. Run once with `stateBits`=0010 and once with 0000. Required: `upc` reaches 5 in the first case and 2 in the second.
- Jump/wrap with AW=4: word 15 has cond=000, word 0 has cond=111, START=15. Required: `upc` goes 15 then 0, then halts; `steps`=2.
- Ignored inputs in RUN: assert `start` and `prog_we`(addr 3, data X) mid-run. Required: the sequence is unaffected and word 3 is unchanged on readback.
- Async reset mid-run: drop `rst_n` between edges in cycle 2 of a run. Required: `busy` and `ctr_word` go to 0 immediately, no `done` pulse, and the program re-runs correctly after release.
